// File: rtl/rs232_tx_arbiter.sv
// Round-robin shares one 8N1 RS232 transmitter between two byte requesters.
// Latency: ready is combinational in IDLE; start bit appears 1 cycle after accept, frame = 10*CLKS_PER_BIT cycles.
// Backpressure: a requester holds valid until its ready; no ready is issued while a frame is in flight or in reset.
module rs232_tx_arbiter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       aValid,
    input  logic [7:0] aData,
    output logic       aReady,
    input  logic       bValid,
    input  logic [7:0] bData,
    output logic       bReady,
    output logic       tx,
    output logic       busy,
    output logic       grantB,
    output logic       txLEDout
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          grant_b_q;

    logic pick_b;
    logic is_idle;
    logic baud_wrap;

    // B wins when alone, or on a tie when A was granted last.
    always_comb begin
        pick_b    = bValid && (!aValid || !grant_b_q);
        is_idle   = resetN && (state_q == IDLE);
        aReady    = is_idle && aValid && !pick_b;
        bReady    = is_idle && pick_b;
        baud_wrap = (baud_q == BAUD_LAST);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            grant_b_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aReady || bReady) begin
                        shift_q   <= bReady ? bData : aData;
                        grant_b_q <= bReady;
                        state_q   <= START;
                        tx_q      <= 1'b0;
                        baud_q    <= '0;
                        bit_q     <= '0;
                    end
                end
                START: begin
                    baud_q <= baud_wrap ? '0 : baud_q + 1'b1;
                    if (baud_wrap) begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    baud_q <= baud_wrap ? '0 : baud_q + 1'b1;
                    if (baud_wrap) begin
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    baud_q <= baud_wrap ? '0 : baud_q + 1'b1;
                    if (baud_wrap) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx       = tx_q;
    assign txLEDout = ~tx_q;
    assign busy     = (state_q != IDLE);
    assign grantB   = grant_b_q;

endmodule
